// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters, one op in flight.
// Latency SETTLE+1 edges accept->resp_valid (illegal ctrl: 1); response holds until owner's resp_ready.
module alu_share_arbiter #(
    parameter int WIDTH  = 64,
    parameter int SETTLE = 1
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_b1,
    input  logic [3:0]       req_ctrl0,
    input  logic [3:0]       req_ctrl1,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_zero,
    output logic             resp_err,
    output logic             busy,
    output logic [WIDTH-1:0] alu_busa,
    output logic [WIDTH-1:0] alu_busb,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_busw,
    input  logic             alu_zero
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_grant_q, last_grant_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] busa_q, busa_d;
    logic [WIDTH-1:0] busb_q, busb_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;

    logic [1:0]       grant;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [3:0]       sel_ctrl;

    function automatic logic ctrl_legal(input logic [3:0] c);
        return (c == 4'h0) || (c == 4'h1) || (c == 4'h2) || (c == 4'h6) || (c == 4'h7);
    endfunction

    // Contention goes to whichever requester was not served last.
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign sel_a    = grant[1] ? req_a1    : req_a0;
    assign sel_b    = grant[1] ? req_b1    : req_b0;
    assign sel_ctrl = grant[1] ? req_ctrl1 : req_ctrl0;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= 4'd0;
            busa_q       <= '0;
            busb_q       <= '0;
            ctrl_q       <= 4'h0;
            data_q       <= '0;
            zero_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            busa_q       <= busa_d;
            busb_q       <= busb_d;
            ctrl_q       <= ctrl_d;
            data_q       <= data_d;
            zero_q       <= zero_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        busa_d       = busa_q;
        busb_d       = busb_q;
        ctrl_d       = ctrl_q;
        data_d       = data_q;
        zero_d       = zero_q;
        err_d        = err_q;
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    owner_d = grant[1];
                    busa_d  = sel_a;
                    busb_d  = sel_b;
                    ctrl_d  = sel_ctrl;
                    if (ctrl_legal(sel_ctrl)) begin
                        state_d = EXEC;
                        cnt_d   = CNT_INIT;
                    end else begin
                        // Illegal code bypasses the ALU; the bus registers still track the request.
                        state_d = RESP;
                        data_d  = '0;
                        zero_d  = 1'b0;
                        err_d   = 1'b1;
                    end
                end
            end
            EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    data_d  = alu_busw;
                    zero_d  = alu_zero;
                    err_d   = 1'b0;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready[owner_q]) begin
                    last_grant_d = owner_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == IDLE) ? grant : 2'b00;
        resp_valid = 2'b00;
        if (state_q == RESP) begin
            resp_valid = owner_q ? 2'b10 : 2'b01;
        end
        busy = (state_q != IDLE);
    end

    assign resp_data = data_q;
    assign resp_zero = zero_q;
    assign resp_err  = err_q;
    assign alu_busa  = busa_q;
    assign alu_busb  = busb_q;
    assign alu_ctrl  = ctrl_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Two instances (SETTLE=1 and SETTLE=4) driven by directed and random operations,
// checked against a transaction-level arbitration/ALU model.
module tb_alu_share_arbiter;

    localparam int W = 64;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic         rst [2];
    logic [1:0]   rv [2], rr [2], rspv [2], rspr [2];
    logic [W-1:0] a0 [2], a1 [2], b0 [2], b1 [2];
    logic [3:0]   c0 [2], c1 [2];
    logic [W-1:0] rd [2], ba [2], bb [2], bw [2];
    logic         rz [2], re [2], bsy [2], bz [2];
    logic [3:0]   bc [2];

    int checks   = 0;
    int failures = 0;
    int lg [2];

    alu_share_arbiter #(.WIDTH(W), .SETTLE(1)) u_dut_s1 (
        .CLK(CLK), .Reset(rst[0]), .req_valid(rv[0]), .req_ready(rr[0]),
        .req_a0(a0[0]), .req_a1(a1[0]), .req_b0(b0[0]), .req_b1(b1[0]),
        .req_ctrl0(c0[0]), .req_ctrl1(c1[0]), .resp_valid(rspv[0]), .resp_ready(rspr[0]),
        .resp_data(rd[0]), .resp_zero(rz[0]), .resp_err(re[0]), .busy(bsy[0]),
        .alu_busa(ba[0]), .alu_busb(bb[0]), .alu_ctrl(bc[0]), .alu_busw(bw[0]), .alu_zero(bz[0])
    );

    alu_share_arbiter #(.WIDTH(W), .SETTLE(4)) u_dut_s4 (
        .CLK(CLK), .Reset(rst[1]), .req_valid(rv[1]), .req_ready(rr[1]),
        .req_a0(a0[1]), .req_a1(a1[1]), .req_b0(b0[1]), .req_b1(b1[1]),
        .req_ctrl0(c0[1]), .req_ctrl1(c1[1]), .resp_valid(rspv[1]), .resp_ready(rspr[1]),
        .resp_data(rd[1]), .resp_zero(rz[1]), .resp_err(re[1]), .busy(bsy[1]),
        .alu_busa(ba[1]), .alu_busb(bb[1]), .alu_ctrl(bc[1]), .alu_busw(bw[1]), .alu_zero(bz[1])
    );

    function automatic logic is_legal(input logic [3:0] c);
        return (c == 4'h0) || (c == 4'h1) || (c == 4'h2) || (c == 4'h6) || (c == 4'h7);
    endfunction

    // Stand-in for the shared ALU; illegal codes yield non-zero junk the block must discard.
    function automatic logic [W-1:0] alu_f(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        case (c)
            4'h0:    return a & b;
            4'h1:    return a | b;
            4'h2:    return a + b;
            4'h6:    return a - b;
            4'h7:    return b;
            default: return a ^ b ^ 64'h5A5A_0000_0000_A5A5;
        endcase
    endfunction

    assign bw[0] = alu_f(bc[0], ba[0], bb[0]);
    assign bw[1] = alu_f(bc[1], ba[1], bb[1]);
    assign bz[0] = (bw[0] == '0);
    assign bz[1] = (bw[1] == '0);

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input int d);
        check_eq("rst_req_ready", 64'(rr[d]), 64'd0);
        check_eq("rst_resp_valid", 64'(rspv[d]), 64'd0);
        check_eq("rst_resp_data", rd[d], 64'd0);
        check_eq("rst_resp_zero", 64'(rz[d]), 64'd0);
        check_eq("rst_resp_err", 64'(re[d]), 64'd0);
        check_eq("rst_busy", 64'(bsy[d]), 64'd0);
        check_eq("rst_busa", ba[d], 64'd0);
        check_eq("rst_busb", bb[d], 64'd0);
        check_eq("rst_ctrl", 64'(bc[d]), 64'd0);
    endtask

    task automatic do_reset(input int d);
        @(negedge CLK);
        rst[d] = 1'b1; rv[d] = 2'b00; rspr[d] = 2'b00;
        @(negedge CLK);
        @(negedge CLK);
        rst[d] = 1'b0;
        #1;
        check_reset_outputs(d);
        lg[d] = 1;
    endtask

    // One complete operation: present, expect grant per round-robin, wait, hold response, retire.
    task automatic op(input int d, input logic [1:0] vm,
                      input logic [W-1:0] xa0, input logic [W-1:0] xb0, input logic [3:0] xc0,
                      input logic [W-1:0] xa1, input logic [W-1:0] xb1, input logic [3:0] xc1,
                      input int hold, output int g, output logic [W-1:0] dat, output logic zf, output logic er);
        logic [W-1:0] ea, eb, edat;
        logic [3:0]   ec;
        logic         ez, ee;
        int           waited;
        int           settle;
        settle = (d == 0) ? 1 : 4;
        @(negedge CLK);
        rv[d] = 2'b00; rspr[d] = 2'b00;
        #1;
        check_eq("idle_ready", 64'(rr[d]), 64'd0);
        check_eq("idle_busy", 64'(bsy[d]), 64'd0);
        @(negedge CLK);
        a0[d] = xa0; b0[d] = xb0; c0[d] = xc0;
        a1[d] = xa1; b1[d] = xb1; c1[d] = xc1;
        rv[d] = vm;
        #1;
        if (vm == 2'b01)      g = 0;
        else if (vm == 2'b10) g = 1;
        else                  g = (lg[d] == 1) ? 0 : 1;
        ea = (g == 1) ? xa1 : xa0;
        eb = (g == 1) ? xb1 : xb0;
        ec = (g == 1) ? xc1 : xc0;
        edat = is_legal(ec) ? alu_f(ec, ea, eb) : '0;
        ez   = is_legal(ec) && (edat == '0);
        ee   = !is_legal(ec);
        check_eq("grant", 64'(rr[d]), 64'(2'b01 << g));
        @(negedge CLK);
        rv[d][g] = 1'b0;
        #1;
        waited = 0;
        while (rspv[d] == 2'b00 && waited < 40) begin
            check_eq("exec_ready", 64'(rr[d]), 64'd0);
            check_eq("exec_busy", 64'(bsy[d]), 64'd1);
            check_eq("exec_busa", ba[d], ea);
            check_eq("exec_busb", bb[d], eb);
            check_eq("exec_ctrl", 64'(bc[d]), 64'(ec));
            @(negedge CLK);
            #1;
            waited++;
        end
        check_eq("latency", 64'(waited), 64'(ee ? 0 : settle));
        for (int k = 0; k <= hold; k++) begin
            rv[d][1-g]   = 1'b1;
            rspr[d][1-g] = 1'($urandom_range(0, 1));
            rspr[d][g]   = (k == hold);
            #1;
            check_eq("resp_valid", 64'(rspv[d]), 64'(2'b01 << g));
            check_eq("resp_data", rd[d], edat);
            check_eq("resp_zero", 64'(rz[d]), 64'(ez));
            check_eq("resp_err", 64'(re[d]), 64'(ee));
            check_eq("resp_ready_blk", 64'(rr[d]), 64'd0);
            check_eq("resp_busy", 64'(bsy[d]), 64'd1);
            check_eq("resp_busa", ba[d], ea);
            dat = rd[d]; zf = rz[d]; er = re[d];
            @(negedge CLK);
        end
        rv[d] = 2'b00; rspr[d] = 2'b00;
        #1;
        check_eq("retire_valid", 64'(rspv[d]), 64'd0);
        check_eq("retire_busy", 64'(bsy[d]), 64'd0);
        lg[d] = g;
    endtask

    task automatic mid_reset(input int d);
        @(negedge CLK);
        a0[d] = 64'hFEDCBA; b0[d] = 64'hABCDEF; c0[d] = 4'h6; rv[d] = 2'b01;
        #1;
        check_eq("mr_grant", 64'(rr[d]), 64'd1);
        @(negedge CLK);
        rv[d] = 2'b00;
        #1;
        check_eq("mr_busy", 64'(bsy[d]), 64'd1);
        @(negedge CLK);
        rst[d] = 1'b1; rspr[d] = 2'b11;
        @(negedge CLK);
        rst[d] = 1'b0;
        #1;
        check_reset_outputs(d);
        lg[d] = 1;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            #1;
            check_eq("mr_no_resp", 64'(rspv[d]), 64'd0);
        end
        rspr[d] = 2'b00;
    endtask

    initial begin
        int           g;
        logic [W-1:0] dat, ra, rb;
        logic         zf, er;
        logic [3:0]   rc, lt [5];
        lt[0] = 4'h0; lt[1] = 4'h1; lt[2] = 4'h2; lt[3] = 4'h6; lt[4] = 4'h7;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; rv[d] = 2'b00; rspr[d] = 2'b00;
            a0[d] = '0; a1[d] = '0; b0[d] = '0; b1[d] = '0; c0[d] = 4'h0; c1[d] = 4'h0;
        end
        do_reset(0);
        do_reset(1);

        op(0, 2'b01, 64'h20, 64'h4500, 4'h2, 64'h0, 64'h0, 4'h0, 0, g, dat, zf, er);
        check_eq("plan_add", dat, 64'h4520);

        do_reset(0);
        op(0, 2'b11, 64'h53F15, 64'h17177, 4'h0, 64'h98967F, 64'hA98AC7, 4'h1, 1, g, dat, zf, er);
        check_eq("plan_rr_first", 64'(g), 64'd0);
        check_eq("plan_and", dat, 64'h13115);
        op(0, 2'b11, 64'h53F15, 64'h17177, 4'h0, 64'h98967F, 64'hA98AC7, 4'h1, 0, g, dat, zf, er);
        check_eq("plan_rr_second", 64'(g), 64'd1);
        check_eq("plan_or", dat, 64'hB99EFF);

        op(0, 2'b10, 64'h0, 64'h0, 4'h0, 64'h999, 64'h0, 4'h7, 0, g, dat, zf, er);
        check_eq("plan_passb", dat, 64'h0);
        check_eq("plan_zero", 64'(zf), 64'd1);
        op(0, 2'b10, 64'h0, 64'h0, 4'h0, 64'h19E0711F, 64'h2246274, 4'h6, 0, g, dat, zf, er);
        check_eq("plan_sub", dat, 64'h17BC0EAB);
        check_eq("plan_sub_zero", 64'(zf), 64'd0);

        op(0, 2'b01, 64'h1234, 64'h5678, 4'h3, 64'h1, 64'h2, 4'h2, 5, g, dat, zf, er);
        check_eq("plan_illegal_err", 64'(er), 64'd1);
        check_eq("plan_illegal_data", dat, 64'h0);

        mid_reset(1);
        op(1, 2'b01, 64'hFEDCBA, 64'hABCDEF, 4'h6, 64'h0, 64'h0, 4'h0, 0, g, dat, zf, er);
        check_eq("plan_reissue", dat, 64'h530ECB);

        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 30; n++) begin
                logic [1:0]   vm;
                logic [W-1:0] xa1, xb1;
                logic [3:0]   xc1;
                vm  = 2'($urandom_range(1, 3));
                ra  = {$urandom, $urandom};
                rb  = ($urandom_range(0, 4) == 0) ? ra : {$urandom, $urandom};
                rc  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : lt[$urandom_range(0, 4)];
                xa1 = {$urandom, $urandom};
                xb1 = ($urandom_range(0, 4) == 0) ? xa1 : {$urandom, $urandom};
                xc1 = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : lt[$urandom_range(0, 4)];
                op(d, vm, ra, rb, rc, xa1, xb1, xc1, $urandom_range(0, 3), g, dat, zf, er);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
